// File: rtl/fetch_pkg.sv
// Shared constants, state/select encodings and instruction helpers for the fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] ECALL_INST       = 32'h0000_0073;
    localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_SEL_INC  = 2'd0,
        PC_SEL_TGT  = 2'd1,
        PC_SEL_HOLD = 2'd2
    } pc_sel_e;

    function automatic logic is_halt_inst(input logic [31:0] word);
        return (word == ECALL_INST) || (word == EBREAK_INST);
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC mux: sequential increment (wrapping), word-aligned redirect target, or hold.
module next_pc_sel
    import fetch_pkg::*;
#(
    parameter int N = 32
) (
    input  pc_sel_e        sel_i,
    input  logic [N-1:0]   pc_i,
    input  logic [N-1:0]   target_i,
    output logic [N-1:0]   next_pc_o
);

    localparam logic [N-1:0] ALIGN_MASK = {{(N-2){1'b1}}, 2'b00};
    localparam logic [N-1:0] PC_STEP    = {{(N-3){1'b0}}, 3'b100};

    logic [N-1:0] pc_inc_s;
    logic [N-1:0] tgt_aligned_s;

    assign pc_inc_s      = pc_i + PC_STEP;
    assign tgt_aligned_s = target_i & ALIGN_MASK;

    // Select the PC for the next cycle
    always_comb begin
        next_pc_o = pc_i;
        case (sel_i)
            PC_SEL_INC:  next_pc_o = pc_inc_s;
            PC_SEL_TGT:  next_pc_o = tgt_aligned_s;
            PC_SEL_HOLD: next_pc_o = pc_i;
            default:     next_pc_o = pc_i;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, IF/ID register, stall/redirect/halt control.
// Optional redirect-misalignment trap enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int          N        = 32,
    parameter int          AW       = 6,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_i,
    input  logic          redirect_i,
    input  logic [N-1:0]  redirect_target_i,
    output logic [AW-1:0] imem_addr_o,
    input  logic [N-1:0]  imem_data_i,
    output logic [N-1:0]  pc_o,
    output logic [N-1:0]  inst_o,
    output logic [N-1:0]  inst_pc_o,
    output logic          valid_o,
    output logic          halted_o
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic          misalign_o
`endif
);

    fetch_state_e state_q, state_d;
    pc_sel_e      pc_sel_s;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] inst_q, inst_d;
    logic [N-1:0] inst_pc_q, inst_pc_d;
    logic         valid_q, valid_d;
`ifdef FETCH_MISALIGN_CHK_EN
    logic         misalign_q, misalign_d;
`endif

    next_pc_sel #(.N(N)) u_next_pc_sel (
        .sel_i     (pc_sel_s),
        .pc_i      (pc_q),
        .target_i  (redirect_target_i),
        .next_pc_o (pc_d)
    );

    // Next-state, PC select and IF/ID register next values
    always_comb begin
        state_d   = state_q;
        pc_sel_s  = PC_SEL_HOLD;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
`ifdef FETCH_MISALIGN_CHK_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            RUN: begin
                if (redirect_i) begin
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
                    // A misaligned target traps instead of loading the PC
                    if (redirect_target_i[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = HALT;
                    end else begin
                        pc_sel_s = PC_SEL_TGT;
                    end
`else
                    pc_sel_s = PC_SEL_TGT;
`endif
                end else if (stall_i) begin
                    pc_sel_s = PC_SEL_HOLD;
                end else begin
                    inst_d    = imem_data_i;
                    inst_pc_d = pc_q;
                    valid_d   = 1'b1;
                    if (is_halt_inst(imem_data_i)) begin
                        state_d  = HALT;
                        pc_sel_s = PC_SEL_HOLD;
                    end else begin
                        pc_sel_s = PC_SEL_INC;
                    end
                end
            end
            HALT: begin
                // The halting instruction stays visible only until the first unstalled cycle
                if (stall_i) begin
                    valid_d = valid_q;
                end else begin
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, PC and IF/ID register update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            inst_q    <= NOP_INST;
            inst_pc_q <= {N{1'b0}};
            valid_q   <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign imem_addr_o = pc_q[AW+1:2];
    assign pc_o        = pc_q;
    assign inst_o      = inst_q;
    assign inst_pc_o   = inst_pc_q;
    assign valid_o     = valid_q;
    assign halted_o    = (state_q == HALT);
`ifdef FETCH_MISALIGN_CHK_EN
    assign misalign_o  = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random stall/redirect/reset traffic.
module tb_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic [5:0]  imem_addr_o;
    logic [31:0] imem_data_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        valid_o;
    logic        halted_o;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        misalign_o;
`endif

    logic [31:0] mem [64];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] m_pc, m_inst, m_inst_pc;
    logic        m_valid, m_halted, m_mis;

    always #5 clk = ~clk;

    assign imem_data_i = mem[imem_addr_o];

    fetch_stage dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .imem_addr_o       (imem_addr_o),
        .imem_data_i       (imem_data_i),
        .pc_o              (pc_o),
        .inst_o            (inst_o),
        .inst_pc_o         (inst_pc_o),
        .valid_o           (valid_o),
        .halted_o          (halted_o)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .misalign_o        (misalign_o)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic rd, input logic [31:0] tgt, input logic st);
        logic [31:0] w;
        if (r) begin
            m_pc = 32'h0; m_inst = NOP; m_inst_pc = 32'h0;
            m_valid = 1'b0; m_halted = 1'b0; m_mis = 1'b0;
        end else if (!m_halted) begin
            if (rd) begin
                m_inst  = NOP;
                m_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
                if (tgt % 4 != 0) begin
                    m_mis    = 1'b1;
                    m_halted = 1'b1;
                end else begin
                    m_pc = tgt;
                end
`else
                m_pc = tgt - (tgt % 4);
`endif
            end else if (!st) begin
                w         = mem[(m_pc / 4) % 64];
                m_inst    = w;
                m_inst_pc = m_pc;
                m_valid   = 1'b1;
                if (w == ECALL || w == EBREAK) m_halted = 1'b1;
                else m_pc = m_pc + 32'd4;
            end
        end else if (!st) begin
            m_valid = 1'b0;
            m_inst  = NOP;
        end
    endtask

    task automatic compare_all();
        check_eq("pc_o", pc_o, m_pc);
        check_eq("imem_addr_o", {26'd0, imem_addr_o}, (m_pc / 4) % 64);
        check_eq("inst_o", inst_o, m_inst);
        check_eq("valid_o", {31'd0, valid_o}, {31'd0, m_valid});
        check_eq("halted_o", {31'd0, halted_o}, {31'd0, m_halted});
        if (m_valid) check_eq("inst_pc_o", inst_pc_o, m_inst_pc);
`ifdef FETCH_MISALIGN_CHK_EN
        check_eq("misalign_o", {31'd0, misalign_o}, {31'd0, m_mis});
`endif
    endtask

    task automatic step(input logic r, input logic rd, input logic [31:0] tgt, input logic st);
        rst = r; redirect_i = rd; redirect_target_i = tgt; stall_i = st;
        @(posedge clk);
        model_update(r, rd, tgt, st);
        #1;
        compare_all();
    endtask

    initial begin
        int halt_cycles;
        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_target_i = 32'h0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = {$urandom} | 32'h0000_0100;
        end
        mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222;
        mem[2] = 32'h3333_3333; mem[3] = 32'h4444_4444;
        mem[5] = ECALL;
        mem[40] = EBREAK;

        // Reset, then free run over words 0..2
        step(1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("reset_inst", inst_o, NOP);
        check_eq("reset_valid", {31'd0, valid_o}, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("run_inst1", inst_o, 32'h2222_2222);
        check_eq("run_pc8", pc_o, 32'h8);

        // Two-cycle stall at pc=8, then resume
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("stall_pc", pc_o, 32'h8);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("resume_inst_pc", inst_pc_o, 32'h8);

        // Redirect wins over stall
        step(1'b0, 1'b1, 32'h0000_0040, 1'b1);
        check_eq("redir_pc", pc_o, 32'h40);
        check_eq("redir_inst", inst_o, NOP);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("redir_inst_pc", inst_pc_o, 32'h40);

        // Run into ECALL at word 5
        step(1'b0, 1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("ecall_inst", inst_o, ECALL);
        check_eq("ecall_halt_pc", pc_o, 32'h14);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0, 1'b0);
        check_eq("halt_ignores_redir", pc_o, 32'h14);
        step(1'b1, 1'b0, 32'h0, 1'b0);

        // PC and word-address wrap
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("wrap_pc", pc_o, 32'h0);
        step(1'b0, 1'b1, 32'h0000_00FC, 1'b0);
        check_eq("addr63", {26'd0, imem_addr_o}, 32'd63);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("addr_wrap", {26'd0, imem_addr_o}, 32'd0);

        // Misaligned redirect
        step(1'b0, 1'b1, 32'h0000_0042, 1'b0);
`ifdef FETCH_MISALIGN_CHK_EN
        check_eq("mis_pc_unchanged", pc_o, 32'h100);
`else
        check_eq("mis_masked_pc", pc_o, 32'h40);
`endif
        step(1'b1, 1'b0, 32'h0, 1'b0);

        // Random traffic
        halt_cycles = 0;
        for (int i = 0; i < 400; i++) begin
            logic r, rd, st;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 99) < 2) || (halt_cycles > 12);
            rd  = ($urandom_range(0, 99) < 10);
            st  = ($urandom_range(0, 99) < 25);
            tgt = {$urandom};
            if ($urandom_range(0, 3) != 0) tgt = {24'd0, tgt[7:2], 2'b00};
            step(r, rd, tgt, st);
            halt_cycles = m_halted ? halt_cycles + 1 : 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32I core. It owns the program counter and drives the word address into the 64-entry instruction memory.
- Registers the returned instruction word, together with its PC, into an IF/ID holding register that the decoder consumes.
- Handles stall, branch/jump redirect with flush, and halt on ECALL/EBREAK.

Parameters:
- N, 32, data/PC width
- AW, 6, instruction-memory word-address width (64 words)
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall_i  in  1  hold PC and IF/ID register (downstream hazard)
- redirect_i  in  1  taken branch/jump from execute
- redirect_target_i  in  N  byte address of redirect target
- imem_addr_o  out  AW  word address to instruction memory (combinational from PC)
- imem_data_i  in  N  instruction word returned combinationally by memory
- pc_o  out  N  current fetch PC
- inst_o  out  N  registered instruction to decoder
- inst_pc_o  out  N  PC of inst_o
- valid_o  out  1  inst_o is a real instruction
- halted_o  out  1  fetch stopped after ECALL/EBREAK

Behaviour:
- Reset (rst=1 at an edge):
  - pc <= RESET_PC; inst_o <= 32'h0000_0013 (NOP); inst_pc_o <= 0; valid_o <= 0; halted_o <= 0; state <= RUN.
  - Reset applied mid-operation discards everything in flight, same values.
- imem_addr_o = pc[AW+1:2], purely combinational. Memory read is zero-latency, so the instruction at pc is available in the same cycle.
- Latency: PC presented in cycle t; inst_o/inst_pc_o/valid_o reflect it from cycle t+1.
- State machine, two states:
  - RUN:
    - Priority is rst > redirect_i > stall_i > normal.
    - redirect_i=1: pc <= {redirect_target_i[N-1:2],2'b00}; inst_o <= NOP; valid_o <= 0 (flush). Redirect wins over a simultaneous stall.
    - stall_i=1 (no redirect): pc, inst_o, inst_pc_o, valid_o all hold.
    - Normal: pc <= pc+4; inst_o <= imem_data_i; inst_pc_o <= pc; valid_o <= 1.
    - If the captured word is 32'h0000_0073 (ECALL) or 32'h0010_0073 (EBREAK), it is latched with valid_o=1, state <= HALT, and pc is not incremented.
  - HALT:
    - halted_o=1, pc frozen.
    - Next non-stalled cycle: valid_o <= 0, inst_o <= NOP. The halt instruction is presented exactly once.
    - redirect_i and stall_i are ignored; only rst leaves HALT.
- Arithmetic: pc+4 wraps modulo 2^N (32'hFFFF_FFFC -> 0). imem_addr_o wraps modulo 2^AW (pc 32'h100 -> addr 0).
- Without the optional feature, target bits [1:0] are silently forced to 0.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - Extra output misalign_o (1 bit, reset 0).
  - A redirect with redirect_target_i[1:0]!=0 does not load pc. Instead: misalign_o <= 1 (sticky until rst), valid_o <= 0, state <= HALT.
- Undefined:
  - Port absent; targets are aligned by masking as above.

Decomposition:
- Shared package fetch_pkg holds:
  - NOP_INST=32'h0000_0013, ECALL_INST, EBREAK_INST
  - state enum {RUN, HALT}
  - RESET_PC default
- One natural sub-module, next_pc_sel: combinational next-PC mux (pc+4 / aligned target / hold), including wrap and alignment logic.
- The FSM and IF/ID register stay in fetch_stage.

Test Plan:
- Reset then free-run, memory preloaded with 4 distinct words -> imem_addr_o 0,1,2,3 on consecutive cycles; inst_o/inst_pc_o = word0/0, word1/4, word2/8 one cycle later; valid_o=0 in the first cycle after reset.
- stall_i=1 for 2 cycles at pc=8 -> pc_o stays 8, inst_o/inst_pc_o/valid_o unchanged; fetch resumes at 8 the cycle after stall drops.
- redirect_i=1 with target 32'h0000_0040 while stall_i=1 -> next cycle pc_o=0x40, valid_o=0, inst_o=0x00000013; following cycle inst_pc_o=0x40, valid_o=1.
- ECALL at word 5 -> inst_o=0x00000073 with valid_o=1 for one cycle, halted_o=1, pc_o frozen at 0x14; a later redirect to 0x0 is ignored; rst restores pc_o=0, halted_o=0.
- PC wrap: redirect to 32'hFFFF_FFFC, one free-run cycle -> pc_o=0, imem_addr_o=0; also pc 0xFC -> 0x100 gives imem_addr_o 63 -> 0.
- With FETCH_MISALIGN_CHK_EN: redirect to 0x0000_0042 -> misalign_o=1, halted_o=1, pc_o unchanged, valid_o=0. Without the macro, the same stimulus -> pc_o=0x40.
